// File: rtl/ascensor_ctrl.sv
// Elevator floor-sequencing controller: drives the external floor counter one step per
// travel period toward an accepted target, then holds the door open before idling.
module ascensor_ctrl #(
  parameter int FLOOR_W     = 4,
  parameter int MAX_FLOOR   = 9,
  parameter int MOVE_CYCLES = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               hold,
  output logic               req_ready,
  output logic               req_err,
  output logic               cnt_enb,
  output logic               cnt_modo,
  output logic [FLOOR_W-1:0] cnt_data,
  input  logic [FLOOR_W-1:0] cnt_q,
  output logic               moving_up,
  output logic               moving_dn,
  output logic               door_open,
  output logic               arrived
);

  localparam int TMR_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {INIT, IDLE, MOVE, STEP, SETTLE, DOOR} state_t;

  state_t             state, state_d;
  logic               started;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [FLOOR_W-1:0] target, target_d;
  logic               dir_up, dir_up_d;
  logic [FLOOR_W-1:0] step_data, step_data_d;
  logic               req_err_d, arrived_d;

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state;
    timer_d     = timer;
    target_d    = target;
    dir_up_d    = dir_up;
    step_data_d = '0;
    req_err_d   = 1'b0;
    arrived_d   = 1'b0;
    unique case (state)
      INIT: if (started) state_d = IDLE;
      IDLE: begin
        if (req_valid) begin
          if (req_floor > FLOOR_W'(MAX_FLOOR)) begin
            req_err_d = 1'b1;
          end else if (req_floor == cnt_q) begin
            arrived_d = 1'b1;
            timer_d   = '0;
            state_d   = DOOR;
          end else begin
            target_d = req_floor;
            dir_up_d = (req_floor > cnt_q);
            timer_d  = '0;
            state_d  = MOVE;
          end
        end
      end
      MOVE: begin
        if (timer == TMR_W'(MOVE_CYCLES - 1)) begin
          timer_d = '0;
          state_d = STEP;
          // Down-step load value is captured here so cnt_data stays a pure register output.
          if (!dir_up) step_data_d = cnt_q - 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      STEP: state_d = SETTLE;
      SETTLE: begin
        timer_d = '0;
        if (cnt_q == target) begin
          arrived_d = 1'b1;
          state_d   = DOOR;
        end else begin
          state_d = MOVE;
        end
      end
      DOOR: begin
        if (hold) begin
          timer_d = '0;
        end else if (timer == TMR_W'(DOOR_CYCLES - 1)) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      started   <= 1'b0;
      timer     <= '0;
      target    <= '0;
      dir_up    <= 1'b0;
      step_data <= '0;
      req_err   <= 1'b0;
      arrived   <= 1'b0;
    end else begin
      state     <= state_d;
      started   <= 1'b1;
      timer     <= timer_d;
      target    <= target_d;
      dir_up    <= dir_up_d;
      step_data <= step_data_d;
      req_err   <= req_err_d;
      arrived   <= arrived_d;
    end
  end

  // INIT only drives the counter once reset has been released for an edge, keeping all
  // outputs low while reset is held.
  logic init_load, travelling;
  assign init_load  = (state == INIT) && started;
  assign travelling = (state == MOVE) || (state == STEP) || (state == SETTLE);

  assign req_ready = (state == IDLE);
  assign cnt_enb   = init_load || (state == STEP);
  assign cnt_modo  = init_load || ((state == STEP) && !dir_up);
  assign cnt_data  = step_data;
  assign moving_up = travelling && dir_up;
  assign moving_dn = travelling && !dir_up;
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_ascensor_ctrl.sv
// Randomized bench for ascensor_ctrl: a behavioural counter plus a per-request trip model
// (distance, direction, door time) judge every request the controller serves.
module tb_ascensor_ctrl;

  localparam int MAX_FLOOR   = 9;
  localparam int MOVE_CYCLES = 3;
  localparam int DOOR_CYCLES = 4;
  localparam int FLOOR_TIME  = MOVE_CYCLES + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = 4'd0;
  logic       hold = 1'b0;
  logic       req_ready, req_err, cnt_enb, cnt_modo;
  logic [3:0] cnt_data;
  logic [3:0] cnt_q = 4'd7;
  logic       moving_up, moving_dn, door_open, arrived;

  int n_checks = 0;
  int n_pass   = 0;
  int floor_m  = 0;

  typedef struct {
    logic [3:0] f;
    int         hold_n;
    bit         early;
  } req_t;

  req_t plan[$];

  ascensor_ctrl #(
    .FLOOR_W(4), .MAX_FLOOR(MAX_FLOOR), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor), .hold(hold),
    .req_ready(req_ready), .req_err(req_err), .cnt_enb(cnt_enb), .cnt_modo(cnt_modo),
    .cnt_data(cnt_data), .cnt_q(cnt_q), .moving_up(moving_up), .moving_dn(moving_dn),
    .door_open(door_open), .arrived(arrived)
  );

  always #5 clk = ~clk;

  // External floor counter: not reset, so only the INIT load can bring it to floor 0.
  always @(posedge clk) begin
    if (cnt_enb) cnt_q <= cnt_modo ? cnt_data : cnt_q + 4'd1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Asserts reset now, then releases it on a falling edge; ends in the first IDLE cycle.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_outs", int'({req_ready, req_err, cnt_enb, cnt_modo, cnt_data,
                              moving_up, moving_dn, door_open, arrived}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("init_load", int'({cnt_enb, cnt_modo, req_ready}), 3'b110);
    check("init_data", int'(cnt_data), 0);
    @(negedge clk);
    check("idle_ready", int'(req_ready), 1);
    check("idle_floor", int'(cnt_q), 0);
    check("idle_enb", int'(cnt_enb), 0);
    floor_m = 0;
  endtask

  // Serves one request from an IDLE cycle and compares the observed trip with the model.
  task automatic run_req(input logic [3:0] f, input int hold_n, input bit early,
                         input logic [3:0] nxt);
    int n = 0, mu = 0, md = 0, eu = 0, ed = 0, dbad = 0, arr = 0, arr_q = -1;
    int err = 0, door = 0, busy = 0, hcnt = hold_n;
    int fi = int'(f);
    bit legal, up;
    int d;
    req_valid = 1'b1;
    req_floor = f;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_floor = 4'($urandom_range(0, 15));
    forever begin
      @(negedge clk);
      n++;
      if (moving_up) mu++;
      if (moving_dn) md++;
      if (cnt_enb && !cnt_modo) eu++;
      if (cnt_enb && cnt_modo) begin
        ed++;
        if (cnt_data != cnt_q - 4'd1) dbad++;
      end
      if (arrived) begin
        arr++;
        arr_q = int'(cnt_q);
      end
      if (req_err) err++;
      if (door_open) begin
        door++;
        hold = (hcnt > 0);
        if (hcnt > 0) hcnt--;
        if (early && door == 2) begin
          req_valid = 1'b1;
          req_floor = nxt;
        end
      end else begin
        hold = 1'b0;
      end
      if (req_ready && (door_open || moving_up || moving_dn)) busy++;
      if (n >= 2 && req_ready) break;
      if (n >= 400) begin
        check("timeout", n, 0);
        finish_run();
      end
    end
    hold = 1'b0;

    legal = (fi <= MAX_FLOOR);
    up    = (fi > floor_m);
    d     = !legal ? 0 : (up ? fi - floor_m : floor_m - fi);
    check("req_err", err, legal ? 0 : 1);
    check("arrived", arr, legal ? 1 : 0);
    if (legal) check("arrived_floor", arr_q, fi);
    check("up_cycles", mu, up ? FLOOR_TIME * d : 0);
    check("dn_cycles", md, up ? 0 : FLOOR_TIME * d);
    check("up_steps", eu, up ? d : 0);
    check("dn_steps", ed, up ? 0 : d);
    check("dn_data", dbad, 0);
    check("door_cycles", door, legal ? DOOR_CYCLES + hold_n : 0);
    check("ready_busy", busy, 0);
    if (legal) floor_m = fi;
    check("floor", int'(cnt_q), floor_m);
  endtask

  initial begin
    int tries;
    #1;
    do_reset();

    plan.push_back('{f: 4'd3,  hold_n: 0, early: 1'b0});
    plan.push_back('{f: 4'd1,  hold_n: 0, early: 1'b0});
    plan.push_back('{f: 4'd1,  hold_n: 0, early: 1'b0});
    plan.push_back('{f: 4'd12, hold_n: 0, early: 1'b0});
    plan.push_back('{f: 4'd1,  hold_n: 6, early: 1'b1});
    plan.push_back('{f: 4'd7,  hold_n: 0, early: 1'b0});
    for (int i = 0; i < 25; i++) begin
      req_t r;
      r.f      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, MAX_FLOOR));
      r.hold_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      r.early  = (r.f <= 4'(MAX_FLOOR)) && ($urandom_range(0, 2) == 0) && (i < 24);
      plan.push_back(r);
    end
    for (int i = 0; i < plan.size(); i++) begin
      run_req(plan[i].f, plan[i].hold_n, plan[i].early,
              (i + 1 < plan.size()) ? plan[i + 1].f : 4'd0);
    end

    // Reset in the middle of a trip, while travelling between floors 2 and 3.
    do_reset();
    req_valid = 1'b1;
    req_floor = 4'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tries = 0;
    do begin
      @(negedge clk);
      tries++;
    end while (cnt_q != 4'd2 && tries < 100);
    check("mid_reach2", int'(cnt_q), 2);
    @(negedge clk);
    check("mid_moving", int'({moving_up, cnt_enb}), 2'b10);
    #2;
    do_reset();
    run_req(4'd4, 0, 1'b0, 4'd0);

    finish_run();
  end

endmodule
